// File: rtl/alb_pkg.sv
// -----------------------------------------------------------------------------
// alb_pkg
// Shared definitions for the ALU sequencer slice: data/address widths, ALU
// opcode and carry-mode encodings, sequencer FSM states, flag bit positions,
// and the carry-in selection helper.
// -----------------------------------------------------------------------------
package alb_pkg;

  localparam int DW   = 4;  // data width
  localparam int AW   = 3;  // register address width
  localparam int NREG = 8;  // register count

  // ALU opcodes, passed straight through to alb_i
  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ANDN = 2'b10;  // ~R & S
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Carry-in modes
  localparam logic [1:0] CM_ZERO  = 2'b00;
  localparam logic [1:0] CM_ONE   = 2'b01;
  localparam logic [1:0] CM_FLAGC = 2'b10;
  localparam logic [1:0] CM_ZERO2 = 2'b11;

  // Flag vector is {C,V,N,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Carry-in for a command given its mode and the current C flag
  function automatic logic carry_in(input logic [1:0] cmode, input logic flag_c);
    logic ci;
    case (cmode)
      CM_ZERO:  ci = 1'b0;
      CM_ONE:   ci = 1'b1;
      CM_FLAGC: ci = flag_c;
      CM_ZERO2: ci = 1'b0;
      default:  ci = 1'b0;
    endcase
    return ci;
  endfunction

endpackage

// File: rtl/alb_regfile.sv
// -----------------------------------------------------------------------------
// alb_regfile
// 8 x 4-bit register file. r0 always reads as zero and writes to it are
// dropped. Two combinational operand read ports, one combinational debug read
// port, one synchronous write port. All entries clear on reset.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ra_addr / ra_data     operand R read port
//   rb_addr / rb_data     operand S read port
//   dbg_addr / dbg_data   debug read port
//   wr_en, wr_addr, wr_data  synchronous write port
// -----------------------------------------------------------------------------
module alb_regfile
  import alb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [NREG];

  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] addr,
                                            input logic [DW-1:0] value);
    return (addr == {AW{1'b0}}) ? {DW{1'b0}} : value;
  endfunction

  // Register storage; address 0 is never written so it stays cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= {DW{1'b0}};
      end
    end else if (wr_en && (wr_addr != {AW{1'b0}})) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read ports force r0 to zero independent of storage
  always_comb begin
    ra_data  = rd_port(ra_addr,  mem[ra_addr]);
    rb_data  = rd_port(rb_addr,  mem[rb_addr]);
    dbg_data = rd_port(dbg_addr, mem[dbg_addr]);
  end

endmodule

// File: rtl/alb_sequencer.sv
// -----------------------------------------------------------------------------
// alb_sequencer
// Accepts one command at a time, fetches operands from the register file,
// presents them to an external ALU (which registers its inputs one cycle),
// then captures the ALU result and flags, writes back and pulses done_valid.
// Flow: IDLE -(accept)-> ISSUE -> CAPTURE -> IDLE, one cycle each.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_valid / cmd_ready       command handshake (ready only in IDLE)
//   cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_bsel, cmd_imm, cmd_cmode, cmd_nowb
//                               command fields
//   alb_r, alb_s, alb_ci, alb_i registered ALU operand/control outputs
//   alb_f, alb_co/vo/no/zo      ALU result and flags
//   done_valid, done_f, flags   completion pulse, result, {C,V,N,Z}
//   dbg_addr / dbg_data         combinational register-file debug read
// -----------------------------------------------------------------------------
module alb_sequencer
  import alb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic          cmd_bsel,
  input  logic [DW-1:0] cmd_imm,
  input  logic [1:0]    cmd_cmode,
  input  logic          cmd_nowb,
  output logic [DW-1:0] alb_r,
  output logic [DW-1:0] alb_s,
  output logic          alb_ci,
  output logic [1:0]    alb_i,
  input  logic [DW-1:0] alb_f,
  input  logic          alb_co,
  input  logic          alb_vo,
  input  logic          alb_no,
  input  logic          alb_zo,
  output logic          done_valid,
  output logic [DW-1:0] done_f,
  output logic [3:0]    flags,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] rd_lat;
  logic          nowb_lat;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          accept;
  logic          wr_en;
  logic [3:0]    alu_flags;

  alb_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .ra_addr  (cmd_ra),
    .ra_data  (ra_data),
    .rb_addr  (cmd_rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_en    (wr_en),
    .wr_addr  (rd_lat),
    .wr_data  (alb_f)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, handshake and write-enable decode
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    wr_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          next_state = ST_ISSUE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        wr_en      = ~nowb_lat;  // r0 writes are dropped by the register file
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Pack ALU flags into {C,V,N,Z}
  always_comb begin
    alu_flags         = 4'b0000;
    alu_flags[FLAG_C] = alb_co;
    alu_flags[FLAG_V] = alb_vo;
    alu_flags[FLAG_N] = alb_no;
    alu_flags[FLAG_Z] = alb_zo;
  end

  // Operand launch on accept; result/flag capture in CAPTURE.
  // alb_* only change on accept, so they hold through ISSUE and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alb_r      <= {DW{1'b0}};
      alb_s      <= {DW{1'b0}};
      alb_ci     <= 1'b0;
      alb_i      <= 2'b00;
      rd_lat     <= {AW{1'b0}};
      nowb_lat   <= 1'b0;
      done_valid <= 1'b0;
      done_f     <= {DW{1'b0}};
      flags      <= 4'b0000;
    end else begin
      done_valid <= (state == ST_CAPTURE);
      if (accept) begin
        alb_r    <= ra_data;
        alb_s    <= cmd_bsel ? cmd_imm : rb_data;
        alb_ci   <= carry_in(cmd_cmode, flags[FLAG_C]);
        alb_i    <= cmd_op;
        rd_lat   <= cmd_rd;
        nowb_lat <= cmd_nowb;
      end
      if (state == ST_CAPTURE) begin
        done_f <= alb_f;
        flags  <= alu_flags;
      end
    end
  end

endmodule

// File: doc/alb_sequencer.md
ALB_SEQUENCER -- requirements
Module: alb_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have cmd_valid input 1, cmd_ready output 1: command handshake; transfer when both high at a clk edge.
REQ-004 SHALL have the command fields as inputs:
- cmd_op[1:0]: 00 OR, 01 ADD, 10 ANDN (~R&S), 11 SUB; driven unchanged onto alb_i.
- cmd_ra[2:0], cmd_rb[2:0], cmd_rd[2:0]: R source, S source and destination register.
- cmd_bsel (1 bit): S operand select, 1 = cmd_imm.
- cmd_imm[3:0]: immediate S value.
- cmd_cmode[1:0]: carry-in mode; 00 CI=0, 01 CI=1, 10 CI=flag C, 11 CI=0.
- cmd_nowb (1 bit): 1 = update flags only, no register write.
REQ-005 SHALL have ALU-side outputs alb_r[3:0], alb_s[3:0], alb_ci (1), alb_i[1:0], all registered.
REQ-006 SHALL have ALU-side inputs alb_f[3:0], alb_co, alb_vo, alb_no, alb_zo, 1 bit each: result and flags of the downstream ALU, which registers its inputs one cycle.
REQ-007 SHALL have outputs done_valid (1), done_f[3:0] and flags[3:0] = {C,V,N,Z}.
REQ-008 SHALL have debug port dbg_addr[2:0] input and dbg_data[3:0] output, combinational register-file read.

Function
REQ-009 SHALL contain an 8 x 4-bit register file; r0 reads as 0 and writes to r0 are discarded.
REQ-010 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> IDLE, one cycle per state; cmd_ready = 1 only in IDLE.
REQ-011 On handshake edge E0: latch cmd; alb_r <= reg[ra]; alb_s <= cmd_bsel ? cmd_imm : reg[rb]; alb_ci per cmd_cmode using current flag C; alb_i <= cmd_op; go ISSUE.
REQ-012 ISSUE: alb_* held stable; the ALU captures them at E1; go CAPTURE.
REQ-013 CAPTURE: at E2 sample alb_f and alb_* flags:
- reg[rd] <= alb_f unless cmd_nowb or rd = 0.
- flags <= {alb_co, alb_vo, alb_no, alb_zo} verbatim.
- done_f <= alb_f; done_valid <= 1; go IDLE.
REQ-014 done_valid SHALL be a single-cycle pulse in the cycle after E2; done_f and flags hold until the next update.
REQ-015 Latency: accept edge to done_valid high SHALL be exactly 2 cycles; max throughput 1 command per 3 cycles.
REQ-016 No forwarding is needed: the next accept (earliest E3) SHALL read the register-file value written at E2, and cmode 10 SHALL use C written at E2.
REQ-017 cmd_* SHALL be ignored while cmd_ready = 0; cmd_valid may stay high without side effects.
REQ-018 alb_* SHALL hold their last values in IDLE.
REQ-019 Writes via cmd_nowb or to r0 SHALL still update flags and pulse done_valid.

Reset
REQ-020 Reset SHALL set: state IDLE, all registers 0, flags 0, done_valid 0, done_f 0, alb_r/alb_s/alb_ci/alb_i 0.
REQ-021 Reset in ISSUE or CAPTURE SHALL abort the command: no register write, no done pulse; cmd_ready = 1 in the first cycle after release.

Structure
REQ-022 Package alb_pkg SHALL hold: opcode constants (OR/ADD/ANDN/SUB), carry-mode constants, FSM state enum, data width 4, register-address width 3, flag bit indices.
REQ-023 Register file SHALL be sub-module alb_regfile (8x4, r0 hardwired zero, 2 combinational read ports, 1 debug read port, 1 synchronous write port); the ALU is instantiated beside this block, not inside it.

Verification
REQ-024 Load: OR ra=0, bsel=1, imm=7, rd=1 -> done_f=7, flags=0000, dbg r1=7, done_valid 2 cycles after accept.
REQ-025 Overflow: ADD ra=1 (7) + imm 1, cmode 00, rd=2 -> done_f=8, flags C0 V1 N1 Z0.
REQ-026 Carry chain: r3=F; ADD r3 + imm 1, cmode 00 -> F=0, C1 Z1; then ADD r0 + imm 0, cmode 10 -> F=1, C0.
REQ-027 Sub: SUB ra=1 (7), imm 7, cmode 01 -> F=0, Z1 C1 (no borrow), V0.
REQ-028 Back-to-back: cmd_valid held high for two commands -> cmd_ready low 2 cycles; second accept 3 cycles after first; second cmd writes rd=0 -> dbg r0 stays 0, flags update.
REQ-029 Reset asserted during CAPTURE of a write to r4 -> no done_valid, r4 = 0, flags 0000, cmd_ready 1 after release.
